// File: rtl/turn_sequencer_if.sv
// Board-store bus between turn_sequencer (master) and the board store (slave).
//
// Handshake: rdEn is a one-cycle read request carrying rdPlayer/rdRow/rdCol;
// the slave must present rdCell exactly one cycle after rdEn is high. There is
// no ready/backpressure on either path. wrEn is a one-cycle write strobe that
// carries wrPlayer/wrRow/wrCol/wrCell in the same cycle.
interface turn_sequencer_if;
  logic       rdEn;
  logic       rdPlayer;
  logic [3:0] rdRow;
  logic [3:0] rdCol;
  logic [1:0] rdCell;
  logic       wrEn;
  logic       wrPlayer;
  logic [3:0] wrRow;
  logic [3:0] wrCol;
  logic [1:0] wrCell;

  modport master (
    output rdEn, rdPlayer, rdRow, rdCol,
    output wrEn, wrPlayer, wrRow, wrCol, wrCell,
    input  rdCell
  );

  modport slave (
    input  rdEn, rdPlayer, rdRow, rdCol,
    input  wrEn, wrPlayer, wrRow, wrCol, wrCell,
    output rdCell
  );
endinterface

// File: rtl/turn_sequencer.sv
// Turn sequencer for the 10x10 two-player board: decodes PS/2 set-2 make
// codes into a shot coordinate, runs a read-modify-write of the opponent's
// cell on Enter, scores hits, swaps turns and detects the win.
// Optional build macro: HIT_AGAIN_EN -- a non-winning hit keeps the turn.
// state_dbg encoding: 0 SEL_L, 1 SEL_N, 2 CONFIRM, 3 RD, 4 EVAL, 5 OVER.
module turn_sequencer #(
  parameter int SHIP_CELLS = 17,
  parameter int CNT_W      = 5
) (
  input  logic             clock50,
  input  logic             resetN,
  input  logic             keyValid,
  input  logic [7:0]       keyCode,
  turn_sequencer_if.master bus,
  output logic             playerTurn,
  output logic [3:0]       letter,
  output logic [3:0]       number,
  output logic             hitPulse,
  output logic             missPulse,
  output logic             repeatPulse,
  output logic [CNT_W-1:0] hits1,
  output logic [CNT_W-1:0] hits2,
  output logic             gameOver,
  output logic             winner,
  output logic             newGame,
  output logic [2:0]       state_dbg
);

  typedef enum logic [2:0] {
    SEL_L   = 3'd0,
    SEL_N   = 3'd1,
    CONFIRM = 3'd2,
    RD      = 3'd3,
    EVAL    = 3'd4,
    OVER    = 3'd5
  } state_t;

  state_t           state, state_n;
  logic             skip, skip_n;
  logic             turn, turn_n;
  logic [3:0]       letter_q, letter_n, number_q, number_n;
  logic             tgt_player, tgt_player_n;
  logic [3:0]       tgt_row, tgt_row_n, tgt_col, tgt_col_n;
  logic             rd_en, rd_en_n, wr_en, wr_en_n;
  logic [1:0]       wr_cell, wr_cell_n;
  logic             hit_p, hit_n, miss_p, miss_n, rep_p, rep_n, new_game, new_game_n;
  logic [CNT_W-1:0] hits1_q, hits1_n, hits2_q, hits2_n, shooter_cnt, cnt_inc;
  logic             winner_q, winner_n;
  logic             key_ok, is_letter, is_digit, is_enter, is_bksp;
  logic [3:0]       key_val;

  // Break filter: an F0 prefix arms skip, which swallows the following byte.
  assign key_ok   = keyValid && !skip && (keyCode != 8'hF0);
  assign is_enter = (keyCode == 8'h5A);
  assign is_bksp  = (keyCode == 8'h66);

  always_comb skip_n = keyValid ? (!skip && (keyCode == 8'hF0)) : skip;

  // Map make codes to row (letters A-J) or column (keys 0-9).
  always_comb begin
    is_letter = 1'b0;
    is_digit  = 1'b0;
    key_val   = 4'hF;
    case (keyCode)
      8'h1C: begin is_letter = 1'b1; key_val = 4'd0; end
      8'h32: begin is_letter = 1'b1; key_val = 4'd1; end
      8'h21: begin is_letter = 1'b1; key_val = 4'd2; end
      8'h23: begin is_letter = 1'b1; key_val = 4'd3; end
      8'h24: begin is_letter = 1'b1; key_val = 4'd4; end
      8'h2B: begin is_letter = 1'b1; key_val = 4'd5; end
      8'h34: begin is_letter = 1'b1; key_val = 4'd6; end
      8'h33: begin is_letter = 1'b1; key_val = 4'd7; end
      8'h43: begin is_letter = 1'b1; key_val = 4'd8; end
      8'h3B: begin is_letter = 1'b1; key_val = 4'd9; end
      8'h45: begin is_digit  = 1'b1; key_val = 4'd0; end
      8'h16: begin is_digit  = 1'b1; key_val = 4'd1; end
      8'h1E: begin is_digit  = 1'b1; key_val = 4'd2; end
      8'h26: begin is_digit  = 1'b1; key_val = 4'd3; end
      8'h25: begin is_digit  = 1'b1; key_val = 4'd4; end
      8'h2E: begin is_digit  = 1'b1; key_val = 4'd5; end
      8'h36: begin is_digit  = 1'b1; key_val = 4'd6; end
      8'h3D: begin is_digit  = 1'b1; key_val = 4'd7; end
      8'h3E: begin is_digit  = 1'b1; key_val = 4'd8; end
      8'h46: begin is_digit  = 1'b1; key_val = 4'd9; end
      default: ;
    endcase
  end

  assign shooter_cnt = turn ? hits2_q : hits1_q;
  assign cnt_inc     = shooter_cnt + CNT_W'(1);

  // Next-state and next-output logic; every output is registered.
  always_comb begin
    state_n      = state;
    turn_n       = turn;
    letter_n     = letter_q;
    number_n     = number_q;
    tgt_player_n = tgt_player;
    tgt_row_n    = tgt_row;
    tgt_col_n    = tgt_col;
    hits1_n      = hits1_q;
    hits2_n      = hits2_q;
    winner_n     = winner_q;
    wr_cell_n    = wr_cell;
    rd_en_n      = 1'b0;
    wr_en_n      = 1'b0;
    hit_n        = 1'b0;
    miss_n       = 1'b0;
    rep_n        = 1'b0;
    new_game_n   = 1'b0;
    case (state)
      SEL_L: begin
        if (key_ok && is_letter) begin
          letter_n = key_val;
          state_n  = SEL_N;
        end
      end
      SEL_N: begin
        if (key_ok) begin
          if (is_digit) begin
            number_n = key_val;
            state_n  = CONFIRM;
          end else if (is_letter) begin
            letter_n = key_val;
          end else if (is_bksp) begin
            letter_n = 4'hF;
            state_n  = SEL_L;
          end
        end
      end
      CONFIRM: begin
        if (key_ok) begin
          if (is_enter) begin
            // Latch the target once; read and write addresses both use it.
            rd_en_n      = 1'b1;
            tgt_player_n = ~turn;
            tgt_row_n    = letter_q;
            tgt_col_n    = number_q;
            state_n      = RD;
          end else if (is_bksp) begin
            number_n = 4'hF;
            state_n  = SEL_N;
          end else if (is_digit) begin
            number_n = key_val;
          end
        end
      end
      RD: state_n = EVAL;
      EVAL: begin
        if (bus.rdCell == 2'b00) begin
          wr_en_n   = 1'b1;
          wr_cell_n = 2'b10;
          miss_n    = 1'b1;
          turn_n    = ~turn;
          letter_n  = 4'hF;
          number_n  = 4'hF;
          state_n   = SEL_L;
        end else if (bus.rdCell == 2'b01) begin
          wr_en_n   = 1'b1;
          wr_cell_n = 2'b11;
          hit_n     = 1'b1;
          letter_n  = 4'hF;
          number_n  = 4'hF;
          if (turn) hits2_n = cnt_inc;
          else      hits1_n = cnt_inc;
          if (cnt_inc == CNT_W'(SHIP_CELLS)) begin
            winner_n = turn;
            state_n  = OVER;
          end else begin
`ifdef HIT_AGAIN_EN
            turn_n   = turn;
`else
            turn_n   = ~turn;
`endif
            state_n  = SEL_L;
          end
        end else begin
          // Cell already shot: report it and let the shooter re-aim.
          rep_n   = 1'b1;
          state_n = CONFIRM;
        end
      end
      OVER: begin
        if (key_ok && is_enter) begin
          new_game_n = 1'b1;
          hits1_n    = '0;
          hits2_n    = '0;
          turn_n     = 1'b0;
          letter_n   = 4'hF;
          number_n   = 4'hF;
          state_n    = SEL_L;
        end
      end
      default: state_n = SEL_L;
    endcase
  end

  // State and output registers; async reset aborts any shot in flight.
  always_ff @(posedge clock50 or negedge resetN) begin
    if (!resetN) begin
      state      <= SEL_L;
      skip       <= 1'b0;
      turn       <= 1'b0;
      letter_q   <= 4'hF;
      number_q   <= 4'hF;
      tgt_player <= 1'b0;
      tgt_row    <= 4'd0;
      tgt_col    <= 4'd0;
      hits1_q    <= '0;
      hits2_q    <= '0;
      winner_q   <= 1'b0;
      wr_cell    <= 2'b00;
      rd_en      <= 1'b0;
      wr_en      <= 1'b0;
      hit_p      <= 1'b0;
      miss_p     <= 1'b0;
      rep_p      <= 1'b0;
      new_game   <= 1'b0;
    end else begin
      state      <= state_n;
      skip       <= skip_n;
      turn       <= turn_n;
      letter_q   <= letter_n;
      number_q   <= number_n;
      tgt_player <= tgt_player_n;
      tgt_row    <= tgt_row_n;
      tgt_col    <= tgt_col_n;
      hits1_q    <= hits1_n;
      hits2_q    <= hits2_n;
      winner_q   <= winner_n;
      wr_cell    <= wr_cell_n;
      rd_en      <= rd_en_n;
      wr_en      <= wr_en_n;
      hit_p      <= hit_n;
      miss_p     <= miss_n;
      rep_p      <= rep_n;
      new_game   <= new_game_n;
    end
  end

  assign bus.rdEn     = rd_en;
  assign bus.rdPlayer = tgt_player;
  assign bus.rdRow    = tgt_row;
  assign bus.rdCol    = tgt_col;
  assign bus.wrEn     = wr_en;
  assign bus.wrPlayer = tgt_player;
  assign bus.wrRow    = tgt_row;
  assign bus.wrCol    = tgt_col;
  assign bus.wrCell   = wr_cell;

  assign playerTurn  = turn;
  assign letter      = letter_q;
  assign number      = number_q;
  assign hitPulse    = hit_p;
  assign missPulse   = miss_p;
  assign repeatPulse = rep_p;
  assign hits1       = hits1_q;
  assign hits2       = hits2_q;
  assign gameOver    = (state == OVER);
  assign winner      = winner_q;
  assign newGame     = new_game;
  assign state_dbg   = state;

endmodule

// File: tb/tb_turn_sequencer.sv
// Directed testbench for turn_sequencer: key entry, miss/hit/repeat shots,
// break-code filtering, win and new game, reset in the middle of a shot.
module tb_turn_sequencer;

  logic       clock50 = 1'b0;
  logic       resetN;
  logic       keyValid;
  logic [7:0] keyCode;
  logic       playerTurn;
  logic [3:0] letter, number;
  logic       hitPulse, missPulse, repeatPulse;
  logic [4:0] hits1, hits2;
  logic       gameOver, winner, newGame;
  logic [2:0] state_dbg;
  logic [1:0] cell_resp;

  int          tests_run    = 0;
  int          tests_failed = 0;
  logic [31:0] obs, req;

`ifdef HIT_AGAIN_EN
  localparam logic HIT_TURN = 1'b0;
`else
  localparam logic HIT_TURN = 1'b1;
`endif

  turn_sequencer_if bus ();

  turn_sequencer #(.SHIP_CELLS(17), .CNT_W(5)) dut (
    .clock50     (clock50),
    .resetN      (resetN),
    .keyValid    (keyValid),
    .keyCode     (keyCode),
    .bus         (bus),
    .playerTurn  (playerTurn),
    .letter      (letter),
    .number      (number),
    .hitPulse    (hitPulse),
    .missPulse   (missPulse),
    .repeatPulse (repeatPulse),
    .hits1       (hits1),
    .hits2       (hits2),
    .gameOver    (gameOver),
    .winner      (winner),
    .newGame     (newGame),
    .state_dbg   (state_dbg)
  );

  // Clock and board model: data answers a read one cycle after rdEn; when
  // idle it shows the complement, so a mistimed sample gives a wrong result.
  always #10 clock50 = ~clock50;

  always @(posedge clock50) bus.rdCell <= bus.rdEn ? cell_resp : ~cell_resp;

  task automatic tick;
    @(negedge clock50);
  endtask

  task automatic press(input logic [7:0] code);
    @(negedge clock50);
    keyValid = 1'b1;
    keyCode  = code;
    @(negedge clock50);
    keyValid = 1'b0;
    keyCode  = 8'h00;
  endtask

  task automatic do_reset;
    resetN   = 1'b0;
    keyValid = 1'b0;
    keyCode  = 8'h00;
    repeat (2) @(negedge clock50);
    resetN = 1'b1;
    @(negedge clock50);
  endtask

  // Select a cell and shoot it, leaving one idle cycle after the write.
  task automatic fire(input logic [7:0] lcode, input logic [7:0] dcode, input logic [1:0] resp);
    press(lcode);
    press(dcode);
    cell_resp = resp;
    press(8'h5A);
    repeat (3) tick();
  endtask

  task automatic test_reset;
    resetN    = 1'b0;
    keyValid  = 1'b0;
    keyCode   = 8'h00;
    cell_resp = 2'b00;
    @(negedge clock50);
    obs = {state_dbg, playerTurn, letter, number, hits1, hits2, winner, gameOver};
    req = {3'd0, 1'b0, 4'hF, 4'hF, 5'd0, 5'd0, 1'b0, 1'b0};
    tests_run++;
    if (obs !== req) begin tests_failed++; $display("FAIL reset_state: got %h, expected %h", obs, req); end
    obs = {bus.rdEn, bus.wrEn, hitPulse, missPulse, repeatPulse, newGame};
    req = 32'd0;
    tests_run++;
    if (obs !== req) begin tests_failed++; $display("FAIL reset_strobes: got %h, expected %h", obs, req); end
    resetN = 1'b1;
    @(negedge clock50);
  endtask

  task automatic test_miss;
    do_reset();
    press(8'h1C);
    obs = {state_dbg, letter};
    req = {3'd1, 4'd0};
    tests_run++;
    if (obs !== req) begin tests_failed++; $display("FAIL miss_letter: got %h, expected %h", obs, req); end
    press(8'h1E);
    obs = {state_dbg, number};
    req = {3'd2, 4'd2};
    tests_run++;
    if (obs !== req) begin tests_failed++; $display("FAIL miss_number: got %h, expected %h", obs, req); end
    cell_resp = 2'b00;
    press(8'h5A);
    obs = {bus.rdEn, bus.rdPlayer, bus.rdRow, bus.rdCol, bus.wrEn};
    req = {1'b1, 1'b1, 4'd0, 4'd2, 1'b0};
    tests_run++;
    if (obs !== req) begin tests_failed++; $display("FAIL miss_rd: got %h, expected %h", obs, req); end
    tick();
    obs = {bus.rdEn, bus.wrEn, state_dbg};
    req = {1'b0, 1'b0, 3'd4};
    tests_run++;
    if (obs !== req) begin tests_failed++; $display("FAIL miss_eval_cycle: got %h, expected %h", obs, req); end
    tick();
    obs = {bus.wrEn, bus.wrPlayer, bus.wrRow, bus.wrCol, bus.wrCell, missPulse, hitPulse, playerTurn, letter, number, state_dbg};
    req = {1'b1, 1'b1, 4'd0, 4'd2, 2'b10, 1'b1, 1'b0, 1'b1, 4'hF, 4'hF, 3'd0};
    tests_run++;
    if (obs !== req) begin tests_failed++; $display("FAIL miss_write: got %h, expected %h", obs, req); end
    tick();
    obs = {bus.wrEn, missPulse};
    req = 32'd0;
    tests_run++;
    if (obs !== req) begin tests_failed++; $display("FAIL miss_strobe_len: got %h, expected %h", obs, req); end
  endtask

  task automatic test_hit;
    do_reset();
    press(8'h1C);
    press(8'h1E);
    cell_resp = 2'b01;
    press(8'h5A);
    tick();
    tick();
    obs = {bus.wrEn, bus.wrPlayer, bus.wrRow, bus.wrCol, bus.wrCell, hitPulse, missPulse, hits1, hits2, playerTurn};
    req = {1'b1, 1'b1, 4'd0, 4'd2, 2'b11, 1'b1, 1'b0, 5'd1, 5'd0, HIT_TURN};
    tests_run++;
    if (obs !== req) begin tests_failed++; $display("FAIL hit_write: got %h, expected %h", obs, req); end
  endtask

  task automatic test_repeat;
    do_reset();
    press(8'h1C);
    press(8'h1E);
    cell_resp = 2'b11;
    press(8'h5A);
    tick();
    obs = {31'd0, bus.wrEn};
    req = 32'd0;
    tests_run++;
    if (obs !== req) begin tests_failed++; $display("FAIL repeat_no_write_early: got %h, expected %h", obs, req); end
    tick();
    obs = {repeatPulse, bus.wrEn, hitPulse, missPulse, playerTurn, state_dbg, letter, number, hits1};
    req = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2, 4'd0, 4'd2, 5'd0};
    tests_run++;
    if (obs !== req) begin tests_failed++; $display("FAIL repeat_result: got %h, expected %h", obs, req); end
  endtask

  task automatic test_break_filter;
    do_reset();
    press(8'h1C);
    press(8'hF0);
    press(8'h24);
    obs = {state_dbg, letter};
    req = {3'd1, 4'd0};
    tests_run++;
    if (obs !== req) begin tests_failed++; $display("FAIL break_drop: got %h, expected %h", obs, req); end
    press(8'h66);
    obs = {state_dbg, letter};
    req = {3'd0, 4'hF};
    tests_run++;
    if (obs !== req) begin tests_failed++; $display("FAIL break_bksp: got %h, expected %h", obs, req); end
    press(8'h24);
    obs = {state_dbg, letter};
    req = {3'd1, 4'd4};
    tests_run++;
    if (obs !== req) begin tests_failed++; $display("FAIL break_after: got %h, expected %h", obs, req); end
    do_reset();
    press(8'h1C);
    press(8'hF0);
    press(8'h1C);
    press(8'h66);
    press(8'h24);
    obs = {state_dbg, letter, number};
    req = {3'd1, 4'd4, 4'hF};
    tests_run++;
    if (obs !== req) begin tests_failed++; $display("FAIL break_sequence: got %h, expected %h", obs, req); end
  endtask

  task automatic test_edit;
    do_reset();
    press(8'h45);
    press(8'h5A);
    obs = {state_dbg, letter};
    req = {3'd0, 4'hF};
    tests_run++;
    if (obs !== req) begin tests_failed++; $display("FAIL edit_sel_l_ignore: got %h, expected %h", obs, req); end
    press(8'h1C);
    press(8'h5A);
    press(8'h32);
    obs = {state_dbg, letter, number};
    req = {3'd1, 4'd1, 4'hF};
    tests_run++;
    if (obs !== req) begin tests_failed++; $display("FAIL edit_letter_replace: got %h, expected %h", obs, req); end
    press(8'h21);
    press(8'h16);
    press(8'h1E);
    obs = {state_dbg, letter, number};
    req = {3'd2, 4'd2, 4'd2};
    tests_run++;
    if (obs !== req) begin tests_failed++; $display("FAIL edit_digit_replace: got %h, expected %h", obs, req); end
    press(8'h66);
    obs = {state_dbg, letter, number};
    req = {3'd1, 4'd2, 4'hF};
    tests_run++;
    if (obs !== req) begin tests_failed++; $display("FAIL edit_confirm_bksp: got %h, expected %h", obs, req); end
    press(8'h46);
    cell_resp = 2'b00;
    press(8'h5A);
    obs = {bus.rdEn, bus.rdPlayer, bus.rdRow, bus.rdCol};
    req = {1'b1, 1'b1, 4'd2, 4'd9};
    tests_run++;
    if (obs !== req) begin tests_failed++; $display("FAIL edit_rd_addr: got %h, expected %h", obs, req); end
    press(8'h3B);
    tick();
    obs = {bus.wrEn, bus.wrRow, bus.wrCol, letter, state_dbg};
    req = {1'b0, 4'd2, 4'd9, 4'hF, 3'd0};
    tests_run++;
    if (obs !== req) begin tests_failed++; $display("FAIL edit_keys_in_shot_dropped: got %h, expected %h", obs, req); end
  endtask

  task automatic test_win;
    do_reset();
    fire(8'h1C, 8'h45, 2'b00);
    for (int i = 0; i < 16; i++) begin
      fire(8'h32, 8'h16, 2'b01);
`ifndef HIT_AGAIN_EN
      fire(8'h1C, 8'h45, 2'b00);
`endif
    end
    obs = {hits1, hits2, playerTurn, gameOver};
    req = {5'd0, 5'd16, 1'b1, 1'b0};
    tests_run++;
    if (obs !== req) begin tests_failed++; $display("FAIL win_preload: got %h, expected %h", obs, req); end
    press(8'h43);
    press(8'h3E);
    cell_resp = 2'b01;
    press(8'h5A);
    tick();
    tick();
    obs = {bus.wrEn, bus.wrPlayer, bus.wrCell, hitPulse, hits2, gameOver, winner, state_dbg};
    req = {1'b1, 1'b0, 2'b11, 1'b1, 5'd17, 1'b1, 1'b1, 3'd5};
    tests_run++;
    if (obs !== req) begin tests_failed++; $display("FAIL win_detect: got %h, expected %h", obs, req); end
    press(8'h1C);
    obs = {gameOver, state_dbg, newGame};
    req = {1'b1, 3'd5, 1'b0};
    tests_run++;
    if (obs !== req) begin tests_failed++; $display("FAIL win_over_ignore: got %h, expected %h", obs, req); end
    press(8'h5A);
    obs = {newGame, hits1, hits2, playerTurn, gameOver, state_dbg, letter, number};
    req = {1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 3'd0, 4'hF, 4'hF};
    tests_run++;
    if (obs !== req) begin tests_failed++; $display("FAIL win_new_game: got %h, expected %h", obs, req); end
    tick();
    obs = {31'd0, newGame};
    req = 32'd0;
    tests_run++;
    if (obs !== req) begin tests_failed++; $display("FAIL win_new_game_len: got %h, expected %h", obs, req); end
  endtask

  task automatic test_reset_mid_shot;
    int wr_seen;
    do_reset();
    press(8'h1C);
    press(8'h1E);
    cell_resp = 2'b00;
    press(8'h5A);
    obs = {bus.rdEn, state_dbg};
    req = {1'b1, 3'd3};
    tests_run++;
    if (obs !== req) begin tests_failed++; $display("FAIL abort_in_rd: got %h, expected %h", obs, req); end
    resetN = 1'b0;
    #1;
    obs = {bus.rdEn, bus.wrEn, state_dbg, letter, number, playerTurn, missPulse, hits1};
    req = {1'b0, 1'b0, 3'd0, 4'hF, 4'hF, 1'b0, 1'b0, 5'd0};
    tests_run++;
    if (obs !== req) begin tests_failed++; $display("FAIL abort_reset_vals: got %h, expected %h", obs, req); end
    repeat (2) tick();
    resetN = 1'b1;
    wr_seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.wrEn === 1'b1) wr_seen++;
    end
    obs = wr_seen;
    req = 32'd0;
    tests_run++;
    if (obs !== req) begin tests_failed++; $display("FAIL abort_no_write: got %h, expected %h", obs, req); end
  endtask

  initial begin
    test_reset();
    test_miss();
    test_hit();
    test_repeat();
    test_break_filter();
    test_edit();
    test_win();
    test_reset_mid_shot();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/turn_sequencer.md
Name: turn_sequencer

Overview:
- Game controller for the 10x10 two-player board. It decodes PS/2 set-2 make codes into a shot coordinate, letter A-J for the row and digit 0-9 for the column.
- On Enter it does a read-modify-write of the target cell in the opponent's board store, scores hits, swaps the player turn and detects the win.
- Sits between the keyboard controller and the board store. It is the single owner of player turn and of every shot write; display controllers only read its outputs.

Parameters:
- SHIP_CELLS, 17: ship cells per player; reaching this many hits ends the game.
- CNT_W, 5: width of the per-player hit counters; must satisfy 2^CNT_W > SHIP_CELLS.

Ports:
- clock50  input  1  system clock, 50 MHz.
- resetN  input  1  asynchronous, active-low reset.
- keyValid  input  1  one-cycle strobe; keyCode holds a new received byte.
- keyCode  input  8  raw PS/2 byte; make codes and F0 break prefixes both arrive here.
- rdEn  output  1  board read request.
- rdPlayer  output  1  board to read; always the target (opponent) board.
- rdRow / rdCol  output  4 / 4  cell address.
- rdCell  input  2  cell data, valid exactly 1 cycle after rdEn. Encoding: 00 water, 01 ship, 10 miss, 11 hit.
- wrEn  output  1  board write strobe.
- wrPlayer, wrRow, wrCol, wrCell  output  1, 4, 4, 2  write address and data.
- playerTurn  output  1  current shooter; 0 = player one.
- letter / number  output  4 / 4  selected row / column; 4'hF = none selected.
- hitPulse / missPulse / repeatPulse  output  1 each  one-cycle shot-result strobes.
- hits1 / hits2  output  CNT_W each  hit counts of player one / player two.
- gameOver  output  1  high while in OVER.
- winner  output  1  winning player; meaningful only while gameOver is high.
- newGame  output  1  one-cycle strobe asking the board store to reload its start boards.

Behaviour:
- Reset values, async on resetN low:
  - state=SEL_L, playerTurn=0, letter=number=4'hF.
  - hits1=hits2=0, winner=0, all strobes 0.
  - Break filter cleared.
- Break filter:
  - keyCode F0 with keyValid sets a skip flag; the next keyValid byte is dropped and the flag clears.
  - Filtered bytes never reach the FSM.
- Key classes:
  - Letters: 1C 32 21 23 24 2B 34 33 43 3B map to rows 0-9 (A-J).
  - Digits: 45 16 1E 26 25 2E 36 3D 3E 46 map to columns 0-9 (keys 0-9).
  - Enter = 5A, Backspace = 66. Every other code is ignored.
- FSM states: SEL_L, SEL_N, CONFIRM, RD, EVAL, OVER.
  - SEL_L: letter key sets letter, then SEL_N. All other keys ignored.
  - SEL_N: digit key sets number, then CONFIRM. A letter key replaces letter and stays in SEL_N. Backspace clears letter, then SEL_L.
  - CONFIRM: Enter pulses rdEn with rdPlayer=~playerTurn, rdRow=letter, rdCol=number, then RD. Backspace clears number, then SEL_N. A digit key replaces number.
  - RD: one wait cycle, then EVAL.
  - EVAL samples rdCell:
    - 00: wrEn with wrCell=10, missPulse.
    - 01: wrEn with wrCell=11, hitPulse, shooter's counter +1.
    - 10 or 11: repeatPulse, no write, no turn change, return to CONFIRM with the selection kept.
  - After EVAL on a hit: if the counter's new value equals SHIP_CELLS, set winner=playerTurn and go to OVER.
  - After EVAL otherwise, for a miss or a non-winning hit: toggle playerTurn, clear letter and number, go to SEL_L.
  - OVER: Enter pulses newGame, zeroes both counters, sets playerTurn=0, clears the selection, then SEL_L. All other keys ignored.
- Key-to-effect latency is 1 cycle: registers update on the edge after keyValid. Enter-to-wrEn latency is 3 cycles: rdEn, RD, EVAL.
- Keys arriving in RD or EVAL are discarded; there is no queueing.
- wrPlayer/wrRow/wrCol hold rdPlayer/rdRow/rdCol for the whole shot.
- Counters never exceed SHIP_CELLS; no wrap is possible.
- Reset asserted mid-shot aborts the shot; no partial write is issued after resetN rises.

Optional Feature:
- HIT_AGAIN_EN defined: a non-winning hit keeps playerTurn unchanged; the shooter fires again.
- HIT_AGAIN_EN undefined: every completed shot (hit or miss) toggles playerTurn. A repeat shot never toggles in either build.

Test Plan:
- Bytes 1C (A), 1E (key 2), 5A; board model returns rdCell=00 -> rdEn with row 0 col 2; wrEn 3 cycles after Enter with wrCell=10; missPulse; playerTurn 0->1; letter=number=F.
- Same entry with rdCell=01 -> wrCell=11, hitPulse, hits1=1. Turn toggles without HIT_AGAIN_EN; stays 0 with it.
- Same entry with rdCell=11 -> repeatPulse, no wrEn, turn unchanged, state CONFIRM with letter=0, number=2.
- Bytes 1C F0 1C 66 24 -> break byte dropped; Backspace clears letter; final letter=4 (E), state SEL_N.
- Preload hits2=16, player two hits a ship cell -> hits2=17, gameOver=1, winner=1. Following 5A -> newGame pulse, counters 0, playerTurn 0.
- Drop resetN low during RD -> all outputs at reset values; no wrEn after release.
